// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate-type encodings for the
// immediate-generation stage and its decoder.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [2:0] {
    IMM_T_NONE = 3'd0,
    IMM_T_I    = 3'd1,
    IMM_T_S    = 3'd2,
    IMM_T_B    = 3'd3,
    IMM_T_U    = 3'd4,
    IMM_T_J    = 3'd5,
    IMM_T_Z    = 3'd6
  } imm_type_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word to extended immediate,
// format type and unsupported-opcode flag.
module imm_decode #(
  parameter int XLEN        = 32,
  parameter bit SIGN_EXTEND = 1'b1,
  parameter bit ZIMM_EN     = 1'b1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            unknown
);
  import imm_pkg::*;

  logic sx;
  logic [XLEN-1:0] u_imm;

  // Every format's top immediate bit is inst[31]; legacy mode forces zero fill.
  always_comb begin
    sx       = SIGN_EXTEND ? inst[31] : 1'b0;
    u_imm    = XLEN'({inst[31:12], 12'b0});
    imm      = '0;
    imm_type = IMM_T_NONE;
    unknown  = 1'b0;
    if (sx) u_imm = u_imm | ~XLEN'(32'hFFFF_FFFF);
    case (inst[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        imm      = {{(XLEN-12){sx}}, inst[31:20]};
        imm_type = IMM_T_I;
      end
      OPC_SYSTEM: begin
        if (ZIMM_EN && inst[14]) begin
          imm      = XLEN'(inst[19:15]);
          imm_type = IMM_T_Z;
        end else begin
          imm      = {{(XLEN-12){sx}}, inst[31:20]};
          imm_type = IMM_T_I;
        end
      end
      OPC_STORE: begin
        imm      = {{(XLEN-12){sx}}, inst[31:25], inst[11:7]};
        imm_type = IMM_T_S;
      end
      OPC_BRANCH: begin
        imm      = {{(XLEN-13){sx}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_type = IMM_T_B;
      end
      OPC_AUIPC, OPC_LUI: begin
        imm      = u_imm;
        imm_type = IMM_T_U;
      end
      OPC_JAL: begin
        imm      = {{(XLEN-21){sx}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_type = IMM_T_J;
      end
      OPC_OP: ;
      default: unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a two-entry skid buffer;
// the branch/jump target is summed on the input side and stored per entry.
module imm_gen_stage #(
  parameter int XLEN        = 32,
  parameter bit SIGN_EXTEND = 1'b1,
  parameter bit ZIMM_EN     = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_target,
  output logic            out_unknown
);
  import imm_pkg::*;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic [XLEN-1:0] target;
    logic            unknown;
  } entry_t;

  entry_t main_q, skid_q, in_entry;
  logic main_valid, skid_valid;
  logic [XLEN-1:0] dec_imm;
  logic [2:0] dec_type;
  logic dec_unknown;
  logic accept, pop;

  imm_decode #(
    .XLEN(XLEN),
    .SIGN_EXTEND(SIGN_EXTEND),
    .ZIMM_EN(ZIMM_EN)
  ) u_decode (
    .inst(in_inst),
    .imm(dec_imm),
    .imm_type(dec_type),
    .unknown(dec_unknown)
  );

  always_comb begin
    in_entry = '{inst: in_inst, pc: in_pc, imm: dec_imm, typ: dec_type,
                 target: in_pc + dec_imm, unknown: dec_unknown};
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready && !flush;
  assign pop      = main_valid && out_ready;

  // Skid only fills while main is stalled, so main always holds the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || (pop && !skid_valid)) begin
      main_valid <= accept;
      if (accept) main_q <= in_entry;
    end else if (pop) begin
      main_q     <= skid_q;
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_q     <= in_entry;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_inst    = main_q.inst;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_type    = main_q.typ;
  assign out_target  = main_q.target;
  assign out_unknown = main_q.unknown;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: default build plus a legacy
// (zero-extend, no zimm) 32-bit build and a 64-bit build.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_valid_v = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;

  logic in_ready, out_valid, out_unknown;
  logic [31:0] out_inst, out_pc, out_imm, out_target;
  logic [2:0] out_type;

  logic l_in_ready, l_out_valid, l_out_unknown;
  logic [31:0] l_out_inst, l_out_pc, l_out_imm, l_out_target;
  logic [2:0] l_out_type;

  logic w_in_ready, w_out_valid, w_out_unknown;
  logic [31:0] w_out_inst;
  logic [63:0] w_out_pc, w_out_imm, w_out_target;
  logic [2:0] w_out_type;

  int checks = 0;
  int errors = 0;
  int pops = 0;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  typ;
    logic [63:0] target;
    logic        unk;
  } exp_t;

  exp_t q_main[$];
  exp_t q_leg[$];
  exp_t q_wide[$];

  always #5 clk = ~clk;

  imm_gen_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_imm(out_imm), .out_type(out_type), .out_target(out_target), .out_unknown(out_unknown)
  );

  imm_gen_stage #(.XLEN(32), .SIGN_EXTEND(1'b0), .ZIMM_EN(1'b0)) dut_leg (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid_v), .in_ready(l_in_ready), .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(l_out_valid), .out_ready(1'b1), .out_inst(l_out_inst), .out_pc(l_out_pc),
    .out_imm(l_out_imm), .out_type(l_out_type), .out_target(l_out_target),
    .out_unknown(l_out_unknown)
  );

  imm_gen_stage #(.XLEN(64), .SIGN_EXTEND(1'b1), .ZIMM_EN(1'b1)) dut_wide (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid_v), .in_ready(w_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_inst(w_out_inst), .out_pc(w_out_pc),
    .out_imm(w_out_imm), .out_type(w_out_type), .out_target(w_out_target),
    .out_unknown(w_out_unknown)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] inst, input logic [63:0] pc,
                              input logic [63:0] imm, input logic [2:0] typ,
                              input logic [63:0] target, input logic unk);
    exp_t e;
    e.inst = inst; e.pc = pc; e.imm = imm; e.typ = typ; e.target = target; e.unk = unk;
    return e;
  endfunction

  task automatic compareEntry(input string tag, input exp_t e, input logic [31:0] inst,
                              input logic [63:0] pc, input logic [63:0] imm,
                              input logic [2:0] typ, input logic [63:0] target,
                              input logic unk);
    checkOutput({tag, " inst"}, 64'(inst), 64'(e.inst));
    checkOutput({tag, " pc"}, pc, e.pc);
    checkOutput({tag, " imm"}, imm, e.imm);
    checkOutput({tag, " type"}, 64'(typ), 64'(e.typ));
    checkOutput({tag, " target"}, target, e.target);
    checkOutput({tag, " unknown"}, 64'(unk), 64'(e.unk));
  endtask

  // Monitors: every output handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pops++;
      if (q_main.size() == 0) checkOutput("main spurious output", 64'(q_main.size()), 64'd1);
      else compareEntry("main", q_main.pop_front(), out_inst, 64'(out_pc), 64'(out_imm),
                        out_type, 64'(out_target), out_unknown);
    end
  end

  always @(negedge clk) begin
    if (!rst && l_out_valid) begin
      if (q_leg.size() == 0) checkOutput("legacy spurious output", 64'(q_leg.size()), 64'd1);
      else compareEntry("legacy", q_leg.pop_front(), l_out_inst, 64'(l_out_pc),
                        64'(l_out_imm), l_out_type, 64'(l_out_target), l_out_unknown);
    end
  end

  always @(negedge clk) begin
    if (!rst && w_out_valid) begin
      if (q_wide.size() == 0) checkOutput("wide spurious output", 64'(q_wide.size()), 64'd1);
      else compareEntry("wide", q_wide.pop_front(), w_out_inst, w_out_pc, w_out_imm,
                        w_out_type, w_out_target, w_out_unknown);
    end
  end

  // Offer one instruction to the default build; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] inst, input logic [63:0] pc, input exp_t e);
    logic rdy;
    int n;
    n = 0;
    in_inst = inst;
    in_pc = pc;
    in_valid = 1'b1;
    do begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    in_valid = 1'b0;
    checkOutput("accept within budget", 64'(rdy), 64'd1);
    if (rdy) q_main.push_back(e);
  endtask

  task automatic applyVariant(input logic [31:0] inst, input logic [63:0] pc,
                              input exp_t el, input exp_t ew);
    in_inst = inst;
    in_pc = pc;
    in_valid_v = 1'b1;
    checkOutput("variant in_ready", 64'({l_in_ready, w_in_ready}), 64'd3);
    @(posedge clk);
    #1;
    in_valid_v = 1'b0;
    q_leg.push_back(el);
    q_wide.push_back(ew);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset out_imm", 64'(out_imm), 64'd0);
    checkOutput("reset out_type", 64'(out_type), 64'd0);
    checkOutput("reset out_target", 64'(out_target), 64'd0);
    checkOutput("reset out_unknown", 64'(out_unknown), 64'd0);

    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(32'hFFF00093, 64'h100, mk(32'hFFF00093, 64'h100, 64'hFFFF_FFFF, 3'd1, 64'hFF, 1'b0));
    applyStimulus(32'h7FF00093, 64'hFFFF_FFF0, mk(32'h7FF00093, 64'hFFFF_FFF0, 64'h7FF, 3'd1, 64'h7EF, 1'b0));
    repeat (2) @(posedge clk); #1;
    checkOutput("idle out_valid", 64'(out_valid), 64'd0);
    applyStimulus(32'hFE000EE3, 64'h1000, mk(32'hFE000EE3, 64'h1000, 64'hFFFF_FFFC, 3'd3, 64'hFFC, 1'b0));
    checkOutput("one-cycle latency out_valid", 64'(out_valid), 64'd1);
    applyStimulus(32'h123452B7, 64'h2000, mk(32'h123452B7, 64'h2000, 64'h1234_5000, 3'd4, 64'h1234_7000, 1'b0));
    applyStimulus(32'h3402D073, 64'h10, mk(32'h3402D073, 64'h10, 64'h5, 3'd6, 64'h15, 1'b0));
    applyStimulus(32'h34029073, 64'h0, mk(32'h34029073, 64'h0, 64'h340, 3'd1, 64'h340, 1'b0));
    applyStimulus(32'hFE512C23, 64'h40, mk(32'hFE512C23, 64'h40, 64'hFFFF_FFF8, 3'd2, 64'h38, 1'b0));
    applyStimulus(32'hFFDFF06F, 64'h3000, mk(32'hFFDFF06F, 64'h3000, 64'hFFFF_FFFC, 3'd5, 64'h2FFC, 1'b0));
    applyStimulus(32'h002081B3, 64'h50, mk(32'h002081B3, 64'h50, 64'h0, 3'd0, 64'h50, 1'b0));
    applyStimulus(32'h0000000B, 64'h20, mk(32'h0000000B, 64'h20, 64'h0, 3'd0, 64'h20, 1'b1));

    applyVariant(32'hFFF00093, 64'h100,
                 mk(32'hFFF00093, 64'h100, 64'hFFF, 3'd1, 64'h10FF, 1'b0),
                 mk(32'hFFF00093, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'hFF, 1'b0));
    applyVariant(32'h3402D073, 64'h100,
                 mk(32'h3402D073, 64'h100, 64'h340, 3'd1, 64'h440, 1'b0),
                 mk(32'h3402D073, 64'h100, 64'h5, 3'd6, 64'h105, 1'b0));
    applyVariant(32'h800002B7, 64'h100,
                 mk(32'h800002B7, 64'h100, 64'h8000_0000, 3'd4, 64'h8000_0100, 1'b0),
                 mk(32'h800002B7, 64'h100, 64'hFFFF_FFFF_8000_0000, 3'd4, 64'hFFFF_FFFF_8000_0100, 1'b0));
    applyVariant(32'hFE000EE3, 64'h1000,
                 mk(32'hFE000EE3, 64'h1000, 64'h1FFC, 3'd3, 64'h2FFC, 1'b0),
                 mk(32'hFE000EE3, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 64'hFFC, 1'b0));
    applyVariant(32'h123452B7, 64'hFFFF_FFFF_FFFF_F000,
                 mk(32'h123452B7, 64'hFFFF_F000, 64'h1234_5000, 3'd4, 64'h1234_4000, 1'b0),
                 mk(32'h123452B7, 64'hFFFF_FFFF_FFFF_F000, 64'h1234_5000, 3'd4, 64'h1234_4000, 1'b0));
    repeat (3) @(posedge clk); #1;

    // Backpressure: A and B fill main and skid, C waits for space.
    out_ready = 1'b0;
    applyStimulus(32'h00100093, 64'hA0, mk(32'h00100093, 64'hA0, 64'h1, 3'd1, 64'hA1, 1'b0));
    applyStimulus(32'h00200093, 64'hB0, mk(32'h00200093, 64'hB0, 64'h2, 3'd1, 64'hB2, 1'b0));
    checkOutput("in_ready after two held", 64'(in_ready), 64'd0);
    p0 = pops;
    fork
      applyStimulus(32'h00300093, 64'hC0, mk(32'h00300093, 64'hC0, 64'h3, 3'd1, 64'hC3, 1'b0));
      begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("C held in_ready", 64'(in_ready), 64'd0);
        checkOutput("no pops while stalled", 64'(pops - p0), 64'd0);
        out_ready = 1'b1;
      end
    join
    @(posedge clk); #1;
    checkOutput("drain pops back-to-back", 64'(pops - p0), 64'd3);
    checkOutput("drain queue empty", 64'(q_main.size()), 64'd0);

    // Flush with two and then one held entry; the flushed-cycle input must vanish.
    for (int held = 2; held >= 1; held--) begin
      out_ready = 1'b0;
      for (int k = 0; k < held; k++)
        applyStimulus(32'h00500093, 64'h500, mk(32'h00500093, 64'h500, 64'h5, 3'd1, 64'h505, 1'b0));
      in_inst = 32'h00700093;
      in_pc = 64'h700;
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      q_main.delete();
      checkOutput("flush out_valid", 64'(out_valid), 64'd0);
      checkOutput("flush in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      p0 = pops;
      repeat (3) @(posedge clk); #1;
      checkOutput("no output after flush", 64'(pops - p0), 64'd0);
    end

    // Asynchronous reset between edges while two entries are held.
    out_ready = 1'b0;
    applyStimulus(32'h00800093, 64'h800, mk(32'h00800093, 64'h800, 64'h8, 3'd1, 64'h808, 1'b0));
    applyStimulus(32'h00900093, 64'h900, mk(32'h00900093, 64'h900, 64'h9, 3'd1, 64'h909, 1'b0));
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("async reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("async reset out_target", 64'(out_target), 64'd0);
    q_main.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    p0 = pops;
    applyStimulus(32'hFFF00093, 64'h100, mk(32'hFFF00093, 64'h100, 64'hFFFF_FFFF, 3'd1, 64'hFF, 1'b0));
    repeat (3) @(posedge clk); #1;
    checkOutput("post-reset pop count", 64'(pops - p0), 64'd1);

    checkOutput("main queue drained", 64'(q_main.size()), 64'd0);
    checkOutput("legacy queue drained", 64'(q_leg.size()), 64'd0);
    checkOutput("wide queue drained", 64'(q_wide.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
